// File: rtl/nvdla_cmac_pkg.sv
// Shared types and width helpers for the CMAC MAC cell and its retiming pipe.
package nvdla_cmac_pkg;

  typedef enum logic {
    PREC_INT8  = 1'b0,
    PREC_INT16 = 1'b1
  } prec_e;

  localparam int OUT_RETIMING_MAX = 4;

  // Width of one gated product; INT16 pairs two lanes into one operand.
  function automatic int prod_width(input int bpe, input bit int16);
    return int16 ? 4 * bpe : 2 * bpe;
  endfunction

  // Exact adder-tree width: widest product plus one growth bit per tree level.
  function automatic int sum_width(input int atomc, input int bpe, input bit int16);
    return prod_width(bpe, int16) + $clog2(atomc);
  endfunction

endpackage

// File: rtl/nvdla_cmac_mac_cell_if.sv
// Activation buses into the MAC cell and its result bus out.
// Handshake: a transfer happens on every clock edge where pvld is high; there is
// no ready/backpressure, so the receiver must accept every valid beat.
interface nvdla_cmac_mac_cell_if #(
  parameter int ATOMC     = 64,
  parameter int BPE       = 8,
  parameter int ACC_WIDTH = 48
);
  logic [ATOMC*BPE-1:0] dat_actv_data;
  logic [ATOMC-1:0]     dat_actv_nz;
  logic [ATOMC-1:0]     dat_actv_pvld;
  logic [ATOMC*BPE-1:0] wt_actv_data;
  logic [ATOMC-1:0]     wt_actv_nz;
  logic [ATOMC-1:0]     wt_actv_pvld;
  logic [ACC_WIDTH-1:0] mac_out_data;
  logic                 mac_out_pvld;

  modport master (
    output dat_actv_data, dat_actv_nz, dat_actv_pvld,
    output wt_actv_data, wt_actv_nz, wt_actv_pvld,
    input  mac_out_data, mac_out_pvld
  );

  modport slave (
    input  dat_actv_data, dat_actv_nz, dat_actv_pvld,
    input  wt_actv_data, wt_actv_nz, wt_actv_pvld,
    output mac_out_data, mac_out_pvld
  );
endinterface

// File: rtl/nvdla_cmac_rtm_pipe.sv
// Valid-enabled retiming chain carrying data, valid and precision tag.
// STAGES = 0 degenerates to wires.
module nvdla_cmac_rtm_pipe
  import nvdla_cmac_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  input  prec_e            in_prec,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output prec_e            out_prec
);

  if (STAGES == 0) begin : g_wire
    assign out_vld  = in_vld;
    assign out_data = in_data;
    assign out_prec = in_prec;
  end else begin : g_reg
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    prec_e             prec_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int s = 0; s < STAGES; s++) begin
          data_q[s] <= '0;
          prec_q[s] <= PREC_INT8;
        end
      end else begin
        vld_q[0] <= in_vld;
        if (in_vld) begin
          data_q[0] <= in_data;
          prec_q[0] <= in_prec;
        end
        for (int s = 1; s < STAGES; s++) begin
          vld_q[s] <= vld_q[s-1];
          if (vld_q[s-1]) begin
            data_q[s] <= data_q[s-1];
            prec_q[s] <= prec_q[s-1];
          end
        end
      end
    end

    assign out_vld  = vld_q[STAGES-1];
    assign out_data = data_q[STAGES-1];
    assign out_prec = prec_q[STAGES-1];
  end

endmodule

// File: rtl/nvdla_cmac_mac_cell.sv
// Pipelined multiply-accumulate cell: gated products, exact adder tree, retiming,
// and a local accumulator over cfg_acc_len+1 atoms. INT16 mode needs NVDLA_CMAC_INT16_EN.
module nvdla_cmac_mac_cell
  import nvdla_cmac_pkg::*;
#(
  parameter int ATOMC        = 64,
  parameter int BPE          = 8,
  parameter int OUT_RETIMING = 2,
  parameter int ACC_WIDTH    = 48
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  cfg_reg_en,
  input  logic                  cfg_precision,
  input  logic [3:0]            cfg_acc_len,
  nvdla_cmac_mac_cell_if.slave  mac_bus
);

`ifdef NVDLA_CMAC_INT16_EN
  localparam bit INT16_EN = 1'b1;
`else
  localparam bit INT16_EN = 1'b0;
`endif
  localparam int P8_W   = prod_width(BPE, 1'b0);
  localparam int SUM_W  = sum_width(ATOMC, BPE, INT16_EN);
  localparam int PROD_W = ATOMC * P8_W;

  if (OUT_RETIMING > OUT_RETIMING_MAX) begin : g_bad_rtm
    $error("OUT_RETIMING exceeds OUT_RETIMING_MAX");
  end

  // ---------------- shadow configuration ----------------
  prec_e      shadow_prec;
  logic [3:0] shadow_acc_len;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)  shadow_acc_len <= '0;
    else if (cfg_reg_en)   shadow_acc_len <= cfg_acc_len;
  end

`ifdef NVDLA_CMAC_INT16_EN
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)  shadow_prec <= PREC_INT8;
    else if (cfg_reg_en)   shadow_prec <= prec_e'(cfg_precision);
  end
`else
  logic cfg_precision_unused;
  assign cfg_precision_unused = cfg_precision;
  assign shadow_prec          = PREC_INT8;
`endif

  // ---------------- stage 1: gated products ----------------
  logic              atom_vld;
  logic [PROD_W-1:0] prod8;
  logic [PROD_W-1:0] prod_d;

  assign atom_vld = mac_bus.dat_actv_pvld[0] & mac_bus.wt_actv_pvld[0];

  for (genvar i = 0; i < ATOMC; i++) begin : g_lane
    logic                   gate8;
    logic signed [P8_W-1:0] p8;
    assign gate8 = mac_bus.wt_actv_pvld[i] & mac_bus.dat_actv_pvld[i] &
                   mac_bus.wt_actv_nz[i]   & mac_bus.dat_actv_nz[i];
    assign p8 = P8_W'($signed(mac_bus.wt_actv_data[i*BPE +: BPE])) *
                P8_W'($signed(mac_bus.dat_actv_data[i*BPE +: BPE]));
    assign prod8[i*P8_W +: P8_W] = gate8 ? p8 : '0;
  end

`ifdef NVDLA_CMAC_INT16_EN
  localparam int P16_W = prod_width(BPE, 1'b1);
  // An INT16 pair product occupies the two INT8 product slots of its lanes.
  logic [PROD_W-1:0] prod16;

  for (genvar j = 0; j < ATOMC/2; j++) begin : g_pair
    logic                    gate16;
    logic signed [P16_W-1:0] p16;
    assign gate16 = (&mac_bus.wt_actv_pvld[2*j +: 2]) & (&mac_bus.dat_actv_pvld[2*j +: 2]) &
                    (|mac_bus.wt_actv_nz[2*j +: 2])   & (|mac_bus.dat_actv_nz[2*j +: 2]);
    assign p16 = P16_W'($signed(mac_bus.wt_actv_data[2*j*BPE +: 2*BPE])) *
                 P16_W'($signed(mac_bus.dat_actv_data[2*j*BPE +: 2*BPE]));
    assign prod16[j*P16_W +: P16_W] = gate16 ? p16 : '0;
  end

  assign prod_d = (shadow_prec == PREC_INT16) ? prod16 : prod8;
`else
  assign prod_d = prod8;
`endif

  logic              s1_vld;
  logic [PROD_W-1:0] s1_prod;
  prec_e             s1_prec;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld  <= 1'b0;
      s1_prod <= '0;
      s1_prec <= PREC_INT8;
    end else begin
      s1_vld <= atom_vld;
      if (atom_vld) begin
        s1_prod <= prod_d;
        s1_prec <= shadow_prec;
      end
    end
  end

  // ---------------- stage 2: exact adder tree ----------------
  logic signed [SUM_W-1:0] sum8;
  logic signed [SUM_W-1:0] sum_d;

  always_comb begin
    sum8 = '0;
    for (int i = 0; i < ATOMC; i++) begin
      sum8 = sum8 + SUM_W'($signed(s1_prod[i*P8_W +: P8_W]));
    end
  end

`ifdef NVDLA_CMAC_INT16_EN
  logic signed [SUM_W-1:0] sum16;

  always_comb begin
    sum16 = '0;
    for (int j = 0; j < ATOMC/2; j++) begin
      sum16 = sum16 + SUM_W'($signed(s1_prod[j*P16_W +: P16_W]));
    end
  end

  assign sum_d = (s1_prec == PREC_INT16) ? sum16 : sum8;
`else
  assign sum_d = sum8;
`endif

  logic             s2_vld;
  logic [SUM_W-1:0] s2_sum;
  prec_e            s2_prec;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s2_vld  <= 1'b0;
      s2_sum  <= '0;
      s2_prec <= PREC_INT8;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_sum  <= sum_d;
        s2_prec <= s1_prec;
      end
    end
  end

  // ---------------- retiming ----------------
  logic             rtm_vld;
  logic [SUM_W-1:0] rtm_sum;
  prec_e            rtm_prec_unused;

  nvdla_cmac_rtm_pipe #(
    .WIDTH  (SUM_W),
    .STAGES (OUT_RETIMING)
  ) u_rtm (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .in_vld   (s2_vld),
    .in_data  (s2_sum),
    .in_prec  (s2_prec),
    .out_vld  (rtm_vld),
    .out_data (rtm_sum),
    .out_prec (rtm_prec_unused)
  );

  // ---------------- accumulator / output ----------------
  logic [3:0]                  acc_cnt;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] sum_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH-1:0]        out_data_q;
  logic                        out_pvld_q;

  assign sum_ext  = ACC_WIDTH'($signed(rtm_sum));
  assign acc_next = (acc_cnt == '0) ? sum_ext : acc_q + sum_ext;

  // A cfg strobe wins over an arriving atom: the atom is dropped with the partial sum.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      acc_cnt    <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_pvld_q <= 1'b0;
    end else begin
      out_pvld_q <= 1'b0;
      if (cfg_reg_en) begin
        acc_cnt <= '0;
      end else if (rtm_vld) begin
        if (acc_cnt == shadow_acc_len) begin
          out_data_q <= acc_next;
          out_pvld_q <= 1'b1;
          acc_cnt    <= '0;
        end else begin
          acc_q   <= acc_next;
          acc_cnt <= acc_cnt + 4'd1;
        end
      end
    end
  end

  assign mac_bus.mac_out_data = out_data_q;
  assign mac_bus.mac_out_pvld = out_pvld_q;

endmodule
